// File: rtl/io_port_pkg.sv
// io_port_pkg: shared constants and types for the SAYEH memory-mapped I/O controller.
//   - default port address map (output base, input base, status register)
//   - bit positions of the port-count fields in the status word
//   - decode-result enum used by the top-level address decoder
package io_port_pkg;

  localparam logic [7:0] OUT_BASE_DEF  = 8'd2;
  localparam logic [7:0] IN_BASE_DEF   = 8'd16;
  localparam logic [7:0] STAT_ADDR_DEF = 8'd31;

  // Status word: [N_IN-1:0] full flags, [11:8] N_IN, [15:12] N_OUT
  localparam int STAT_NIN_LSB  = 8;
  localparam int STAT_NOUT_LSB = 12;

  typedef enum logic [1:0] {
    DEC_OUT,
    DEC_IN,
    DEC_STAT,
    DEC_NONE
  } dec_e;

endpackage

// File: rtl/io_in_buffer.sv
// io_in_buffer: single-entry input holding register with valid/ready capture.
//   clk, Reset       : clock, async active-high reset (buffer emptied)
//   in_data/in_valid : producer side; captured when valid and empty
//   in_ready         : high while the buffer is empty
//   clr              : CPU consumed the word; empties the buffer
//   data/full        : held word and occupancy flag
module io_in_buffer #(
  parameter int PORT_W = 8
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [PORT_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clr,
  output logic [PORT_W-1:0] data,
  output logic              full
);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      data <= '0;
      full <= 1'b0;
    end else if (in_valid && !full) begin
      data <= in_data;
      full <= 1'b1;
    end else if (clr) begin
      // clr is only raised for a full buffer, so it never races a capture
      full <= 1'b0;
    end
  end

  assign in_ready = ~full;

endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: memory-mapped I/O controller for the SAYEH CPU.
//   clk, Reset          : clock, async active-high reset
//   WriteIO, ReadIO     : CPU I/O strobes (both together = illegal)
//   PortAddr, WrData    : port address and write data
//   RdData              : registered, zero-extended read data
//   out_data/out_strobe : N_OUT latched output ports + one-cycle write pulses
//   in_data/in_valid/in_ready : N_IN buffered input ports
//   io_err              : one-cycle pulse on an illegal access
module io_port_ctrl
  import io_port_pkg::*;
#(
  parameter int         DATA_W    = 16,
  parameter int         PORT_W    = 8,
  parameter int         N_OUT     = 4,
  parameter int         N_IN      = 4,
  parameter logic [7:0] OUT_BASE  = OUT_BASE_DEF,
  parameter logic [7:0] IN_BASE   = IN_BASE_DEF,
  parameter logic [7:0] STAT_ADDR = STAT_ADDR_DEF
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    WriteIO,
  input  logic                    ReadIO,
  input  logic [7:0]              PortAddr,
  input  logic [DATA_W-1:0]       WrData,
  output logic [DATA_W-1:0]       RdData,
  output logic [N_OUT*PORT_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_strobe,
  input  logic [N_IN*PORT_W-1:0]  in_data,
  input  logic [N_IN-1:0]         in_valid,
  output logic [N_IN-1:0]         in_ready,
  output logic                    io_err
);

  localparam int OUT_LO = int'(OUT_BASE);
  localparam int OUT_HI = int'(OUT_BASE) + N_OUT - 1;
  localparam int IN_LO  = int'(IN_BASE);
  localparam int IN_HI  = int'(IN_BASE) + N_IN - 1;
  localparam int STAT   = int'(STAT_ADDR);
  localparam logic [3:0] NOUT4 = 4'(N_OUT);
  localparam logic [3:0] NIN4  = 4'(N_IN);

  if (PORT_W > DATA_W || DATA_W < 16) begin : g_chk_width
    $error("io_port_ctrl: need PORT_W <= DATA_W and DATA_W >= 16");
  end
  if (N_IN < 1 || N_IN > 8 || N_OUT < 1 || N_OUT > 8) begin : g_chk_count
    $error("io_port_ctrl: N_IN and N_OUT must be 1..8");
  end
  if (OUT_HI > 255 || IN_HI > 255) begin : g_chk_range
    $error("io_port_ctrl: port range exceeds 8-bit address space");
  end
  if (!(OUT_HI < IN_LO || IN_HI < OUT_LO)) begin : g_chk_overlap
    $error("io_port_ctrl: input and output ranges overlap");
  end
  if ((STAT >= OUT_LO && STAT <= OUT_HI) || (STAT >= IN_LO && STAT <= IN_HI)) begin : g_chk_stat
    $error("io_port_ctrl: STAT_ADDR overlaps a port range");
  end

  logic [N_OUT-1:0][PORT_W-1:0] out_q;
  logic [N_IN-1:0][PORT_W-1:0]  buf_data;
  logic [N_IN-1:0]              full, clr;
  logic [N_OUT-1:0]             out_hit;
  logic [N_IN-1:0]              in_hit;
  logic                         wr_ok, rd_ok, err_next;
  logic [DATA_W-1:0]            rd_next;
  dec_e                         dec;

  assign wr_ok = WriteIO & ~ReadIO;
  assign rd_ok = ReadIO & ~WriteIO;

  always_comb begin
    out_hit = '0;
    in_hit  = '0;
    for (int k = 0; k < N_OUT; k++) out_hit[k] = (int'(PortAddr) == OUT_LO + k);
    for (int k = 0; k < N_IN; k++)  in_hit[k]  = (int'(PortAddr) == IN_LO + k);
    if (|out_hit)                    dec = DEC_OUT;
    else if (|in_hit)                dec = DEC_IN;
    else if (PortAddr == STAT_ADDR)  dec = DEC_STAT;
    else                             dec = DEC_NONE;
  end

  // Consume only a word that is actually held; an empty-port read is a no-op.
  assign clr = {N_IN{rd_ok}} & in_hit & full;

  always_comb begin
    rd_next = '0;
    if (rd_ok) begin
      case (dec)
        DEC_OUT:
          for (int k = 0; k < N_OUT; k++)
            if (out_hit[k]) rd_next[PORT_W-1:0] = out_q[k];
        DEC_IN:
          for (int k = 0; k < N_IN; k++)
            if (in_hit[k] && full[k]) rd_next[PORT_W-1:0] = buf_data[k];
        DEC_STAT: begin
          rd_next[N_IN-1:0]            = full;
          rd_next[STAT_NOUT_LSB +: 4]  = NOUT4;
          rd_next[STAT_NIN_LSB +: 4]   = NIN4;
        end
        default: rd_next = '0;
      endcase
    end
  end

  assign err_next = (WriteIO & ReadIO) | (wr_ok & (dec != DEC_OUT)) |
                    (rd_ok & (dec == DEC_NONE));

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      out_q      <= '0;
      out_strobe <= '0;
      RdData     <= '0;
      io_err     <= 1'b0;
    end else begin
      out_strobe <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        if (wr_ok && out_hit[k]) begin
          out_q[k]      <= WrData[PORT_W-1:0];
          out_strobe[k] <= 1'b1;
        end
      end
      RdData <= rd_next;
      io_err <= err_next;
    end
  end

  assign out_data = out_q;

  if (PORT_W < DATA_W) begin : g_unused_wr
    logic unused_wr_hi;
    assign unused_wr_hi = ^WrData[DATA_W-1:PORT_W];
  end

  for (genvar k = 0; k < N_IN; k++) begin : g_in
    io_in_buffer #(.PORT_W(PORT_W)) u_buf (
      .clk      (clk),
      .Reset    (Reset),
      .in_data  (in_data[k*PORT_W +: PORT_W]),
      .in_valid (in_valid[k]),
      .in_ready (in_ready[k]),
      .clr      (clr[k]),
      .data     (buf_data[k]),
      .full     (full[k])
    );
  end

endmodule
